mma_icb_arbiter: RTL and testbench

//  Shares the MMA engine's single ICB memory port among NREQ requesters:
//  0=weight fetch, 1=bias/quant-param fetch, 2=IA fetch, 3=output FIFO writeback.
//  It arbitrates commands round-robin, records the issuer of each accepted command in
//  an in-order tag FIFO, and routes each response back to that issuer. It sits between
//  the MMA controller's fetch/store engines and the LSU.

---
 rtl/mma_icb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mma_icb_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mma_icb_arbiter.sv
// mma_icb_arbiter
//   Shares the MMA engine's single ICB memory port among NREQ requesters
//   (0=weight fetch, 1=bias/quant-param fetch, 2=IA fetch, 3=output writeback).
//   Commands are arbitrated round-robin. The issuer of each accepted command is
//   recorded in an in-order tag FIFO, and each response is routed back to that issuer.
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_cmd_*                 per-requester ICB command channel (addr/wdata/wmask sliced by index)
//   req_rsp_*                 per-requester response channel (rdata/err shared, valid one-hot)
//   m_cmd_*, m_rsp_*          ICB master port towards the LSU
//   busy                      commands outstanding or any requester asking
//   proto_err                 sticky: a response arrived with no command outstanding
module mma_icb_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_cmd_valid,
  input  logic [NREQ-1:0]            req_cmd_read,
  input  logic [NREQ*ADDR_W-1:0]     req_cmd_addr,
  input  logic [NREQ*DATA_W-1:0]     req_cmd_wdata,
  input  logic [NREQ*DATA_W/8-1:0]   req_cmd_wmask,
  output logic [NREQ-1:0]            req_cmd_ready,
  output logic [NREQ-1:0]            req_rsp_valid,
  output logic [DATA_W-1:0]          req_rsp_rdata,
  output logic                       req_rsp_err,
  input  logic [NREQ-1:0]            req_rsp_ready,
  output logic                       m_cmd_valid,
  output logic                       m_cmd_read,
  output logic [ADDR_W-1:0]          m_cmd_addr,
  output logic [DATA_W-1:0]          m_cmd_wdata,
  output logic [DATA_W/8-1:0]        m_cmd_wmask,
  input  logic                       m_cmd_ready,
  input  logic                       m_rsp_valid,
  input  logic [DATA_W-1:0]          m_rsp_rdata,
  input  logic                       m_rsp_err,
  output logic                       m_rsp_ready,
  output logic                       busy,
  output logic                       proto_err
);

  localparam int unsigned MaskW = DATA_W / 8;
  localparam int unsigned IdxW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PtrW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CntW  = $clog2(OUTSTANDING + 1);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            proto_err_q, proto_err_d;
  logic [IdxW-1:0] tag_mem_q [OUTSTANDING];
  logic [IdxW-1:0] tag_mem_d [OUTSTANDING];

  logic            arb_found;
  logic [IdxW-1:0] arb_idx;
  logic [IdxW-1:0] scan_sel;
  int              scan_idx;
  logic [IdxW-1:0] gnt_idx;
  logic            cmd_req, cmd_hs;
  logic            fifo_full, fifo_empty;
  logic [IdxW-1:0] head;
  logic            rsp_pop;

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan_idx  = 0;
    scan_sel  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % int'(NREQ);
      scan_sel = IdxW'(scan_idx);
      if (!arb_found && req_cmd_valid[scan_sel]) begin
        arb_found = 1'b1;
        arb_idx   = scan_sel;
      end
    end
  end

  // Command path: while locked the grant is frozen even if the requester drops valid.
  always_comb begin
    gnt_idx     = (state_q == StLocked) ? gnt_q : arb_idx;
    cmd_req     = (state_q == StLocked) | arb_found;
    fifo_full   = (count_q == CntW'(OUTSTANDING));
    fifo_empty  = (count_q == '0);
    // Full blocks issue even if a pop is happening now: no m_rsp -> m_cmd_valid path.
    m_cmd_valid = cmd_req & ~fifo_full;
    m_cmd_read  = req_cmd_read[gnt_idx];
    m_cmd_addr  = req_cmd_addr[gnt_idx*ADDR_W +: ADDR_W];
    m_cmd_wdata = req_cmd_wdata[gnt_idx*DATA_W +: DATA_W];
    m_cmd_wmask = req_cmd_wmask[gnt_idx*MaskW +: MaskW];
    cmd_hs      = m_cmd_valid & m_cmd_ready;
    req_cmd_ready = '0;
    if (cmd_hs) req_cmd_ready[gnt_idx] = 1'b1;
  end

  // Response path: route to the FIFO head; with no tag outstanding, drain and flag.
  always_comb begin
    head          = tag_mem_q[rd_ptr_q];
    req_rsp_valid = '0;
    req_rsp_rdata = m_rsp_rdata;
    req_rsp_err   = m_rsp_err;
    if (fifo_empty) begin
      m_rsp_ready = m_rsp_valid;
    end else begin
      req_rsp_valid[head] = m_rsp_valid;
      m_rsp_ready         = req_rsp_ready[head];
    end
    rsp_pop   = m_rsp_valid & m_rsp_ready & ~fifo_empty;
    busy      = (count_q != '0) | (|req_cmd_valid);
    proto_err = proto_err_q;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    proto_err_d = proto_err_q | (m_rsp_valid & fifo_empty);
    tag_mem_d   = tag_mem_q;

    if (cmd_hs) begin
      state_d             = StIdle;
      rr_ptr_d            = (gnt_idx == IdxW'(NREQ - 1)) ? '0 : gnt_idx + IdxW'(1);
      tag_mem_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d            = (wr_ptr_q == PtrW'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end else if (m_cmd_valid) begin
      state_d = StLocked;
      gnt_d   = gnt_idx;
    end

    if (rsp_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end

    if (cmd_hs && !rsp_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!cmd_hs && rsp_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end

endmodule

// File: tb/tb_mma_icb_arbiter.sv
module tb_mma_icb_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int OUTS = 4;
  localparam int MW   = DW / 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_cmd_valid = '0;
  logic [NREQ-1:0]      req_cmd_read  = '0;
  logic [NREQ*AW-1:0]   req_cmd_addr  = '0;
  logic [NREQ*DW-1:0]   req_cmd_wdata = '0;
  logic [NREQ*MW-1:0]   req_cmd_wmask = '0;
  logic [NREQ-1:0]      req_cmd_ready;
  logic [NREQ-1:0]      req_rsp_valid;
  logic [DW-1:0]        req_rsp_rdata;
  logic                 req_rsp_err;
  logic [NREQ-1:0]      req_rsp_ready = '0;
  logic                 m_cmd_valid;
  logic                 m_cmd_read;
  logic [AW-1:0]        m_cmd_addr;
  logic [DW-1:0]        m_cmd_wdata;
  logic [MW-1:0]        m_cmd_wmask;
  logic                 m_cmd_ready = 1'b0;
  logic                 m_rsp_valid = 1'b0;
  logic [DW-1:0]        m_rsp_rdata = '0;
  logic                 m_rsp_err   = 1'b0;
  logic                 m_rsp_ready;
  logic                 busy;
  logic                 proto_err;

  int total = 0;
  int bad   = 0;

  mma_icb_arbiter #(
    .NREQ       (NREQ),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .OUTSTANDING(OUTS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_cmd_valid(req_cmd_valid),
    .req_cmd_read (req_cmd_read),
    .req_cmd_addr (req_cmd_addr),
    .req_cmd_wdata(req_cmd_wdata),
    .req_cmd_wmask(req_cmd_wmask),
    .req_cmd_ready(req_cmd_ready),
    .req_rsp_valid(req_rsp_valid),
    .req_rsp_rdata(req_rsp_rdata),
    .req_rsp_err  (req_rsp_err),
    .req_rsp_ready(req_rsp_ready),
    .m_cmd_valid  (m_cmd_valid),
    .m_cmd_read   (m_cmd_read),
    .m_cmd_addr   (m_cmd_addr),
    .m_cmd_wdata  (m_cmd_wdata),
    .m_cmd_wmask  (m_cmd_wmask),
    .m_cmd_ready  (m_cmd_ready),
    .m_rsp_valid  (m_rsp_valid),
    .m_rsp_rdata  (m_rsp_rdata),
    .m_rsp_err    (m_rsp_err),
    .m_rsp_ready  (m_rsp_ready),
    .busy         (busy),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: queue of issuers still owed a response, the requester after the last
  // winner, the requester whose offer is pending (-1 if none), sticky error.
  int mq[$];
  int last = 0;
  int held = -1;
  bit perr = 1'b0;

  // Winner = valid requester at the smallest round-robin distance from 'last'.
  function automatic int pick();
    int best, bestd, d;
    if (held >= 0) return held;
    best  = -1;
    bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - last + NREQ) % NREQ;
      if (req_cmd_valid[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    mq.delete();
    last = 0;
    held = -1;
    perr = 1'b0;
  endtask

  task automatic model_step();
    int c;
    bit mv;
    c  = pick();
    mv = (c >= 0) && (mq.size() < OUTS);
    if (m_rsp_valid) begin
      if (mq.size() == 0) perr = 1'b1;
      else if (req_rsp_ready[mq[0]]) void'(mq.pop_front());
    end
    if (mv && m_cmd_ready) begin
      mq.push_back(c);
      last = (c + 1) % NREQ;
      held = -1;
    end else if (mv) begin
      held = c;
    end
  endtask

  task automatic compare();
    int c, h;
    bit mv;
    logic [NREQ-1:0] erv, ecr;
    logic emr;
    c  = pick();
    mv = (c >= 0) && (mq.size() < OUTS);
    check("m_cmd_valid", m_cmd_valid, mv);
    if (mv) begin
      check("m_cmd_read", m_cmd_read, req_cmd_read[c]);
      check("m_cmd_addr", m_cmd_addr, req_cmd_addr[c*AW +: AW]);
      check("m_cmd_wdata", m_cmd_wdata, req_cmd_wdata[c*DW +: DW]);
      check("m_cmd_wmask", m_cmd_wmask, req_cmd_wmask[c*MW +: MW]);
    end
    ecr = '0;
    if (mv && m_cmd_ready) ecr[c] = 1'b1;
    check("req_cmd_ready", req_cmd_ready, ecr);
    erv = '0;
    if (mq.size() == 0) begin
      emr = m_rsp_valid;
    end else begin
      h      = mq[0];
      erv[h] = m_rsp_valid;
      emr    = req_rsp_ready[h];
    end
    check("req_rsp_valid", req_rsp_valid, erv);
    check("m_rsp_ready", m_rsp_ready, emr);
    check("req_rsp_rdata", req_rsp_rdata, m_rsp_rdata);
    check("req_rsp_err", req_rsp_err, m_rsp_err);
    check("busy", busy, (mq.size() != 0) || (|req_cmd_valid));
    check("proto_err", proto_err, perr);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      compare();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [NREQ-1:0] exp_rot [6];

  initial begin
    exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < NREQ; i++) begin
      req_cmd_addr[i*AW +: AW]  = 32'h1000_0000 + 32'(i) * 32'h0000_0110;
      req_cmd_wdata[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
      req_cmd_wmask[i*MW +: MW] = 4'(1 << i);
    end
    req_cmd_read  = 4'b0101;
    req_rsp_ready = 4'hF;

    // Reset state
    tick();
    #1;
    check("rst_m_cmd_valid", m_cmd_valid, 1'b0);
    check("rst_m_rsp_ready", m_rsp_ready, 1'b0);
    check("rst_proto_err", proto_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;

    // 1) Single read from requester 2
    tick();
    req_cmd_valid = 4'b0100;
    m_cmd_ready   = 1'b1;
    #1;
    check("t1_cmd_ready", req_cmd_ready, 4'b0100);
    check("t1_addr", m_cmd_addr, 32'h1000_0220);
    check("t1_read", m_cmd_read, 1'b1);
    tick();
    req_cmd_valid = '0;
    m_rsp_valid   = 1'b1;
    m_rsp_rdata   = 32'hDEAD_BEEF;
    #1;
    check("t1_rsp_valid", req_rsp_valid, 4'b0100);
    check("t1_rsp_rdata", req_rsp_rdata, 32'hDEAD_BEEF);
    tick();
    m_rsp_valid = 1'b0;

    // 2) All four requesting, rotation 0,1,2,3,0,1
    rst_pulse();
    for (int k = 0; k < 6; k++) begin
      tick();
      req_cmd_valid = 4'hF;
      m_rsp_valid   = (k > 0);
      m_rsp_rdata   = 32'h0000_2000 + 32'(k);
      #1;
      check("t2_grant", req_cmd_ready, exp_rot[k]);
    end
    tick();
    req_cmd_valid = '0;
    m_rsp_valid   = 1'b1;
    #1;
    check("t2_last_rsp", req_rsp_valid, 4'b0010);
    tick();
    m_rsp_valid = 1'b0;

    // 3) Requester 1 held while LSU stalls; requester 0 joins in cycle 1
    tick();
    req_cmd_valid = 4'b0010;
    m_cmd_ready   = 1'b0;
    #1;
    check("t3_addr_c0", m_cmd_addr, 32'h1000_0110);
    for (int k = 1; k < 3; k++) begin
      tick();
      req_cmd_valid = 4'b0011;
      #1;
      check("t3_addr_held", m_cmd_addr, 32'h1000_0110);
      check("t3_no_ready", req_cmd_ready, 4'b0000);
    end
    tick();
    m_cmd_ready = 1'b1;
    #1;
    check("t3_hs_req1", req_cmd_ready, 4'b0010);
    tick();
    #1;
    check("t3_next_req0", req_cmd_ready, 4'b0001);
    tick();
    req_cmd_valid = '0;
    m_rsp_valid   = 1'b1;
    #1;
    check("t3_rsp1", req_rsp_valid, 4'b0010);
    tick();
    #1;
    check("t3_rsp0", req_rsp_valid, 4'b0001);
    tick();
    m_rsp_valid = 1'b0;

    // 4) Tag FIFO fills; fifth command waits for a pop
    for (int k = 0; k < 4; k++) begin
      tick();
      req_cmd_valid = 4'hF;
    end
    tick();
    #1;
    check("t4_full_hold", m_cmd_valid, 1'b0);
    check("t4_full_busy", busy, 1'b1);
    tick();
    m_rsp_valid = 1'b1;
    #1;
    check("t4_first_rsp", req_rsp_valid, 4'b0010);
    check("t4_full_pop_cycle", m_cmd_valid, 1'b0);
    tick();
    m_rsp_valid = 1'b0;
    #1;
    check("t4_resume", req_cmd_ready, 4'b0010);
    tick();
    req_cmd_valid = '0;
    m_rsp_valid   = 1'b1;
    #1;
    check("t4_rsp_b", req_rsp_valid, 4'b0100);
    tick();
    #1;
    check("t4_rsp_c", req_rsp_valid, 4'b1000);
    tick();
    #1;
    check("t4_rsp_d", req_rsp_valid, 4'b0001);
    tick();
    #1;
    check("t4_rsp_e", req_rsp_valid, 4'b0010);
    tick();
    m_rsp_valid = 1'b0;
    #1;
    check("t4_idle", busy, 1'b0);

    // 5) Requester 3 back-pressures its response
    tick();
    req_cmd_valid = 4'b1000;
    #1;
    check("t5_cmd3", req_cmd_ready, 4'b1000);
    tick();
    req_cmd_valid = 4'b0001;
    tick();
    req_cmd_valid = '0;
    m_rsp_valid   = 1'b1;
    m_rsp_rdata   = 32'hCAFE_0003;
    m_rsp_err     = 1'b1;
    req_rsp_ready = 4'b0111;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t5_stall_ready", m_rsp_ready, 1'b0);
      check("t5_stall_valid", req_rsp_valid, 4'b1000);
      check("t5_stall_err", req_rsp_err, 1'b1);
      tick();
    end
    req_rsp_ready = 4'hF;
    #1;
    check("t5_accept", m_rsp_ready, 1'b1);
    tick();
    m_rsp_rdata = 32'h0000_0A0A;
    m_rsp_err   = 1'b0;
    #1;
    check("t5_next", req_rsp_valid, 4'b0001);
    tick();
    m_rsp_valid = 1'b0;

    // 6) Reset with two outstanding, then an orphan response
    tick();
    req_cmd_valid = 4'b0011;
    tick();
    tick();
    req_cmd_valid = '0;
    rst           = 1'b1;
    #1;
    check("t6_in_reset", m_cmd_valid, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    m_rsp_valid = 1'b1;
    #1;
    check("t6_drain", m_rsp_ready, 1'b1);
    check("t6_no_route", req_rsp_valid, 4'b0000);
    tick();
    m_rsp_valid = 1'b0;
    #1;
    check("t6_proto_err", proto_err, 1'b1);
    repeat (3) tick();
    check("t6_proto_sticky", proto_err, 1'b1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
